// File: rtl/output_score_buffer_if.sv
// Handshake and score bus between the output-layer MAC, the score buffer and argmax.
// The master modport is the upstream/downstream side; the slave modport is the buffer.
interface output_score_buffer_if #(
   parameter int ACC_W       = 24,
   parameter int NUM_CLASSES = 10
);
   // valid/ready: a beat (or frame) transfers on a rising edge where valid and
   // ready are both high; the producer holds its payload stable while ready is low.
   logic                         in_valid;
   logic                         in_ready;
   logic [ACC_W-1:0]             in_acc;
   logic                         in_last;
   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_CLASSES-1:0][7:0]  score;
   logic                         frame_err;

   modport master (
      output in_valid, in_acc, in_last, out_ready,
      input  in_ready, out_valid, score, frame_err
   );

   modport slave (
      input  in_valid, in_acc, in_last, out_ready,
      output in_ready, out_valid, score, frame_err
   );
endinterface

// File: rtl/output_score_buffer.sv
// Collects NUM_CLASSES accumulator beats, requantises each to an 8-bit score and holds the
// frame for argmax. Define SCORE_ROUND_EN for round-half-up instead of floor requantisation.
module output_score_buffer #(
   parameter int ACC_W       = 24,
   parameter int SHIFT       = 8,
   parameter int NUM_CLASSES = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output_score_buffer_if.slave   bus,
   output logic [0:0]             o_dbg_state
);
   localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

`ifdef SCORE_ROUND_EN
   localparam logic [ACC_W:0] RND = (ACC_W+1)'(1) << (SHIFT - 1);
`else
   localparam logic [ACC_W:0] RND = '0;
`endif

   logic [0:0]                  r_state;
   logic [IDX_W-1:0]            r_wr_idx;
   logic                        r_frame_err;
   logic [NUM_CLASSES-1:0][7:0] r_score;

   logic                        w_fill;
   logic                        w_accept;
   logic                        w_last_idx;
   logic signed [ACC_W:0]       w_sum;
   logic signed [ACC_W:0]       w_t;
   logic [7:0]                  w_q;

   assign w_fill     = (r_state == ST_FILL);
   assign w_accept   = bus.in_valid && w_fill;
   assign w_last_idx = (r_wr_idx == LAST_IDX);

   // One extra bit keeps the rounding add from wrapping a large positive accumulator.
   always_comb begin
      w_sum = $signed({bus.in_acc[ACC_W-1], bus.in_acc}) + $signed(RND);
      w_t   = w_sum >>> SHIFT;
      if (w_t[ACC_W])
         w_q = 8'h00;
      else if (|w_t[ACC_W-1:8])
         w_q = 8'hFF;
      else
         w_q = w_t[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_FILL;
         r_wr_idx    <= '0;
         r_frame_err <= 1'b0;
         r_score     <= '0;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            ST_FILL: begin
               if (w_accept) begin
                  // in_last must coincide exactly with the final class slot.
                  if (bus.in_last != w_last_idx) begin
                     r_wr_idx    <= '0;
                     r_frame_err <= 1'b1;
                  end else begin
                     r_score[r_wr_idx] <= w_q;
                     if (w_last_idx) begin
                        r_wr_idx <= '0;
                        r_state  <= ST_HOLD;
                     end else begin
                        r_wr_idx <= r_wr_idx + IDX_W'(1);
                     end
                  end
               end
            end
            default: begin
               if (bus.out_ready)
                  r_state <= ST_FILL;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_fill;
   assign bus.out_valid = (r_state == ST_HOLD);
   assign bus.score     = r_score;
   assign bus.frame_err = r_frame_err;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_output_score_buffer.sv
// Directed bench for output_score_buffer: known frame, HOLD behaviour, short/long frames,
// back-to-back throughput and asynchronous reset mid-frame and in HOLD.
module tb_output_score_buffer;
   localparam int ACC_W = 24;
   localparam int NC    = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [0:0] dbg_state;

   output_score_buffer_if #(.ACC_W(ACC_W), .NUM_CLASSES(NC)) bus ();

   output_score_buffer #(.ACC_W(ACC_W), .SHIFT(8), .NUM_CLASSES(NC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int         n_checks   = 0;
   int         n_fail     = 0;
   int         err_pulses = 0;
   logic [7:0] exp_q[$];

   logic [23:0] plan_acc [NC] = '{24'h000A00, 24'h7FFFFF, 24'hFFFF00, 24'h000000, 24'h00FF00,
                                  24'h010000, 24'h000100, 24'h000280, 24'h800000, 24'h0003FF};
`ifdef SCORE_ROUND_EN
   logic [7:0]  plan_exp [NC] = '{8'd10, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd1, 8'd3, 8'd0, 8'd4};
`else
   logic [7:0]  plan_exp [NC] = '{8'd10, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd1, 8'd2, 8'd0, 8'd3};
`endif

   always @(negedge clk) begin
      if (bus.frame_err === 1'b1) err_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_acc   = '0;
   endtask

   task automatic beat(input logic [23:0] acc, input logic last);
      bus.in_valid = 1'b1;
      bus.in_acc   = acc;
      bus.in_last  = last;
      tick();
   endtask

   task automatic send_ramp(input int base);
      for (int j = 0; j < NC; j++) begin
         exp_q.push_back(8'(base + j));
         beat(24'((base + j) << 8), j == NC - 1);
      end
      idle();
   endtask

   task automatic check_frame(input string tag);
      logic [7:0] e;
      for (int i = 0; i < NC; i++) begin
         if (exp_q.size() == 0) begin
            check($sformatf("%s exp_q underflow", tag), 32'(exp_q.size()), 32'(NC - i));
            return;
         end
         e = exp_q.pop_front();
         check($sformatf("%s score[%0d]", tag, i), 32'(bus.score[i]), 32'(e));
      end
   endtask

   task automatic consume(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, " out_valid cleared"}, 32'(bus.out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, " frame_err"}, 32'(bus.frame_err), 32'd0);
      check({tag, " score zero"}, 32'(|bus.score), 32'd0);
      check({tag, " state"}, 32'(dbg_state), 32'd0);
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int e0;
      int k;
      int frames_seen;
      int last_ov;
      logic rdy;

      rst_n         = 1'b0;
      bus.out_ready = 1'b0;
      idle();
      tick();
      tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Known frame, consumer not ready
      for (int i = 0; i < NC; i++) begin
         exp_q.push_back(plan_exp[i]);
         beat(plan_acc[i], i == NC - 1);
         if (i == NC - 2) check("plan out_valid early", 32'(bus.out_valid), 32'd0);
      end
      check("plan out_valid latency", 32'(bus.out_valid), 32'd1);
      check("plan in_ready low", 32'(bus.in_ready), 32'd0);
      check_frame("plan");
      for (int c = 0; c < 3; c++) begin
         beat(24'h00FF00, 1'b0);
         check("hold in_ready", 32'(bus.in_ready), 32'd0);
         check("hold score0 frozen", 32'(bus.score[0]), 32'(plan_exp[0]));
      end
      idle();
      consume("plan");

      // Short frame: in_last on beat 4
      e0 = err_pulses;
      for (int i = 0; i < 4; i++) beat(24'((i + 70) << 8), i == 3);
      idle();
      check("short frame_err", 32'(bus.frame_err), 32'd1);
      check("short no out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("short frame_err one cycle", 32'(bus.frame_err), 32'd0);
      check("short pulse count", 32'(err_pulses - e0), 32'd1);
      send_ramp(100);
      check("after short out_valid", 32'(bus.out_valid), 32'd1);
      check_frame("after short");
      consume("after short");

      // Long frame: 11 beats, no in_last
      for (int i = 0; i < NC; i++) begin
         beat(24'((i + 40) << 8), 1'b0);
         if (i == NC - 2) check("long no err early", 32'(bus.frame_err), 32'd0);
      end
      check("long frame_err on beat 10", 32'(bus.frame_err), 32'd1);
      check("long no out_valid", 32'(bus.out_valid), 32'd0);
      exp_q.push_back(8'd17);
      beat(24'h001100, 1'b0);
      check("long beat 11 score0", 32'(bus.score[0]), 32'd17);
      check("long beat 11 no err", 32'(bus.frame_err), 32'd0);
      for (int j = 1; j < NC; j++) begin
         exp_q.push_back(8'(17 + j));
         beat(24'((17 + j) << 8), j == NC - 1);
      end
      idle();
      check("long restart out_valid", 32'(bus.out_valid), 32'd1);
      check_frame("long restart");
      consume("long restart");

      // Back-to-back frames with valid and ready held high
      bus.out_ready = 1'b1;
      k = 0;
      frames_seen = 0;
      last_ov = -1;
      for (int c = 0; c < 60 && frames_seen < 3; c++) begin
         bus.in_valid = 1'b1;
         bus.in_acc   = 24'((k + 1) << 8);
         bus.in_last  = ((k % NC) == NC - 1);
         rdy = bus.in_ready;
         tick();
         if (rdy) k++;
         if (bus.out_valid) begin
            if (last_ov >= 0) check("b2b period", 32'(c - last_ov), 32'd11);
            for (int i = 0; i < NC; i++)
               check($sformatf("b2b f%0d score[%0d]", frames_seen, i), 32'(bus.score[i]),
                     32'(frames_seen * NC + i + 1));
            frames_seen++;
            last_ov = c;
         end
      end
      check("b2b frames seen", 32'(frames_seen), 32'd3);
      idle();
      tick();
      bus.out_ready = 1'b0;
      check("b2b drained", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset after beat 6
      for (int i = 0; i < 6; i++) beat(24'((i + 200) << 8), 1'b0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid reset");
      tick();
      rst_n = 1'b1;
      send_ramp(50);
      check("post mid reset out_valid", 32'(bus.out_valid), 32'd1);
      check_frame("post mid reset");

      // Asynchronous reset while in HOLD
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("hold reset");
      tick();
      rst_n = 1'b1;
      send_ramp(60);
      check("post hold reset out_valid", 32'(bus.out_valid), 32'd1);
      check_frame("post hold reset");
      consume("post hold reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/output_score_buffer.md
# output_score_buffer

Collects the ten per-class accumulator results streamed out of the output-layer MAC and requantises each to an 8-bit unsigned score. It holds the complete score vector stable under a valid/ready handshake. It sits directly upstream of the combinational argmax stage that turns `score[0:9]` into the predicted digit.

## Interface
- `ACC_W`, 24: width of the signed accumulator beat.
- `SHIFT`, 8: right-shift applied before saturation; legal range 1..ACC_W-1.
- `NUM_CLASSES`, 10: beats per frame; the argmax stage requires 10.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: upstream beat valid.
- `in_ready`  out  1: buffer accepts a beat; registered, equals (state == FILL).
- `in_acc`  in  ACC_W: signed accumulator for class `wr_idx`.
- `in_last`  in  1: marks the final beat of a frame.
- `out_valid`  out  1: `score` holds a complete frame; registered.
- `out_ready`  in  1: downstream consumes the frame.
- `score`  out  8 x [0:NUM_CLASSES-1]: unsigned scores, one register per class.
- `frame_err`  out  1: one-cycle pulse when a malformed frame is dropped; registered.

## Operation
- **States.**
  - FILL: accepting beats.
  - HOLD: frame complete, waiting for the consumer.
- **Accept.** A beat is accepted when `in_valid && in_ready`. Internal `wr_idx` (0..NUM_CLASSES-1) selects the destination register.
- **Requantisation.** For each accepted beat, in order:
  1. Compute `t = in_acc >>> SHIFT` (arithmetic shift). Work in ACC_W+1 bits so nothing overflows.
  2. If `t < 0`, the score is 0.
  3. Else if `t > 255`, the score is 255.
  4. Otherwise the score is `t[7:0]`.
- **Write.** `score[wr_idx]` gets the requantised value and `wr_idx` increments.
- **Frame completion.** An accepted beat with `in_last=1` and `wr_idx == NUM_CLASSES-1`:
  - writes its score;
  - resets `wr_idx` to 0;
  - moves the state to HOLD;
  - sets `out_valid=1` on the next cycle.
- **Malformed frames.** Either case below drops the frame:
  - an accepted beat with `in_last=1` and `wr_idx < NUM_CLASSES-1` (short frame);
  - an accepted beat with `in_last=0` and `wr_idx == NUM_CLASSES-1` (long frame).

  On a drop:
  - the offending beat is not written;
  - `wr_idx` resets to 0;
  - the state stays FILL;
  - `frame_err` pulses for exactly one cycle.

  Scores already written from the dropped frame remain in the registers but are never presented as valid.
- **HOLD.**
  - `in_ready=0`.
  - `score` is frozen.
  - When `out_valid && out_ready`, the state returns to FILL and `out_valid` clears on the next cycle.
- **Between frames.** During FILL, `score` entries change as they are written. The consumer samples `score` only while `out_valid=1`.
- **Reset.** Asserting `rst_n` at any point, including mid-frame or in HOLD, immediately forces:
  - state FILL, `wr_idx=0`;
  - `in_ready=1`, `out_valid=0`, `frame_err=0`;
  - all `score` entries 0.

## Timing
- Throughput in FILL is one beat per cycle; no bubbles between beats.
- Latency from the last beat's accept edge to `out_valid=1` is 1 cycle. `in_ready` falls on the same edge.
- Minimum frame period is NUM_CLASSES + 1 cycles: 10 beats plus 1 handshake cycle when `out_ready` is held high.
- `in_ready` depends only on state; there is no combinational path from `out_ready` to `in_ready`. After the consume edge, `in_ready=1` on the following cycle.
- `frame_err` is asserted on the cycle after the offending accept edge.
- A beat presented during HOLD is not accepted (`in_ready=0`). Upstream must hold it stable until `in_ready` returns.
- After reset deassertion, the first beat can be accepted on the first rising edge.

## Configuration
- `SCORE_ROUND_EN` defined:
  - add `1 << (SHIFT-1)` to `in_acc` in ACC_W+1 bits before the shift (round-half-up);
  - saturation is applied after rounding.
- Undefined: pure truncation (floor) through the arithmetic shift.
- No other behaviour changes between the two builds.

## Test plan
- Ten beats with `in_acc` = 0x000A00, 0x7FFFFF, 0xFFFF00, 0x000000, 0x00FF00, 0x010000, 0x000100, 0x000280, 0x800000, 0x0003FF, `in_last` on beat 10, `out_ready=0`. Required:
  - `out_valid` rises 1 cycle after beat 10;
  - `score` = {10, 255, 0, 0, 255, 255, 1, 2, 0, 3} (truncating build);
  - `in_ready=0` until `out_ready` is pulsed.
- Same stimulus with `SCORE_ROUND_EN` defined. Required: entry 7 (0x000280) reads 3, entry 9 (0x0003FF) reads 4, all others unchanged.
- Short frame with `in_last` on beat 4. Required:
  - `frame_err` pulses once;
  - no `out_valid`;
  - a following correct 10-beat frame completes normally with the correct scores.
- Long frame: 11 beats with `in_last` never asserted. Required: `frame_err` pulses on beat 10; beat 11 is the first beat of a new frame (`score[0]` written).
- Back-to-back frames with `out_ready=1` and `in_valid=1` continuously. Required: one frame per 11 cycles, and `score` is stable on every `out_valid` cycle.
- Assert `rst_n=0` after beat 6, and separately during HOLD. Required: all outputs return to their reset values asynchronously, and the next frame starts at `score[0]`.
